// File: rtl/gsram_dp_rmw_if.sv
// ---------------------------------------------------------------------------
// gsram_dp_rmw_if
// Carries one request/response port of gsram_dp_rmw. The wrapper has two
// ports, so two instances of this interface are used.
//   A    word address            D    write data
//   WE   1 = write, 0 = read     WEM  bit write mask (1 = bit written)
//   CE   request                 RDY  port can accept a request this cycle
//   Q    read data               QV   one-cycle strobe: Q holds fresh data
// master: request side (drives A/D/WE/WEM/CE)
// slave : wrapper side (drives RDY/Q/QV)
// ---------------------------------------------------------------------------
interface gsram_dp_rmw_if #(
  parameter int ABITS = 10,
  parameter int DBITS = 16
);
  logic [ABITS-1:0] A;
  logic [DBITS-1:0] D;
  logic             WE;
  logic [DBITS-1:0] WEM;
  logic             CE;
  logic             RDY;
  logic [DBITS-1:0] Q;
  logic             QV;

  modport master (output A, D, WE, WEM, CE, input RDY, Q, QV);
  modport slave  (input A, D, WE, WEM, CE, output RDY, Q, QV);
endinterface

// File: rtl/gsram_dp_rmw.sv
// ---------------------------------------------------------------------------
// gsram_dp_rmw
// Dual-port SRAM wrapper that turns masked writes into an internal
// read-modify-write, returns read-valid strobes and resolves port collisions.
// Ports:
//   CLK   clock, all state changes on the rising edge
//   RST   asynchronous, active-high reset (array contents are kept)
//   p0,p1 request/response ports (gsram_dp_rmw_if.slave)
//   COLL  one-cycle strobe: a port-1 write was dropped by a collision
// Behaviour per port:
//   read          -> Q/QV one cycle after acceptance (read-first)
//   full write    -> written at the accepting edge, stays ready
//   null write    -> accepted, no array access, no strobe
//   partial write -> array read at acceptance, merged write one edge later
//                    (RDY low meanwhile); the merge base is forwarded from
//                    the other port if it writes the same word at that edge
// Write/write collision on one address: port 0 wins, COLL pulses.
// Build option GSRAM_OUT_REG_EN: Q/QV pass through one extra register
// (read latency 2); the RMW path keeps using the raw array output.
// ---------------------------------------------------------------------------
module gsram_dp_rmw #(
  parameter int ABITS = 10,
  parameter int DBITS = 16
) (
  input  logic          CLK,
  input  logic          RST,
  gsram_dp_rmw_if.slave p0,
  gsram_dp_rmw_if.slave p1,
  output logic          COLL
);
  localparam int DEPTH = 1 << ABITS;

  typedef enum logic {ST_IDLE = 1'b0, ST_MERGE = 1'b1} state_e;

  logic [DBITS-1:0] mem [DEPTH];

  // Per-port request view, indexed by port number.
  logic [ABITS-1:0] req_a   [2];
  logic [DBITS-1:0] req_d   [2];
  logic [DBITS-1:0] req_wem [2];
  logic [1:0]       req_we;
  logic [1:0]       req_ce;

  assign req_a[0]   = p0.A;
  assign req_a[1]   = p1.A;
  assign req_d[0]   = p0.D;
  assign req_d[1]   = p1.D;
  assign req_wem[0] = p0.WEM;
  assign req_wem[1] = p1.WEM;
  assign req_we     = {p1.WE, p0.WE};
  assign req_ce     = {p1.CE, p0.CE};

  state_e           state_q   [2];
  state_e           state_d   [2];
  logic [1:0]       rdy_q, rdy_d;
  logic [DBITS-1:0] q_q       [2];
  logic [DBITS-1:0] q_d       [2];
  logic [1:0]       qv_q, qv_d;
  logic [ABITS-1:0] lat_a_q   [2];
  logic [ABITS-1:0] lat_a_d   [2];
  logic [DBITS-1:0] lat_d_q   [2];
  logic [DBITS-1:0] lat_d_d   [2];
  logic [DBITS-1:0] lat_wem_q [2];
  logic [DBITS-1:0] lat_wem_d [2];
  logic [DBITS-1:0] base_q    [2];
  logic [DBITS-1:0] base_d    [2];
  logic             coll_q, coll_d;

  logic [1:0]       rd_acc, full_wr, part_wr;
  logic [1:0]       wr_en;
  logic [ABITS-1:0] wr_addr [2];
  logic [DBITS-1:0] wr_data [2];

  // Request decode and the array write each port presents at this edge.
  // NOTE: combinational blocks use blocking '=' and assign a default to every
  // output first, so no latch is inferred; flops are only written with '<='.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      rd_acc[n]  = req_ce[n] & rdy_q[n] & ~req_we[n];
      full_wr[n] = req_ce[n] & rdy_q[n] & req_we[n] & (req_wem[n] == '1);
      part_wr[n] = req_ce[n] & rdy_q[n] & req_we[n] &
                   (req_wem[n] != '0) & (req_wem[n] != '1);
      wr_en[n]   = 1'b0;
      wr_addr[n] = req_a[n];
      wr_data[n] = req_d[n];
      // Writes are blocked while RST is high so a pending merge is discarded.
      if (state_q[n] == ST_MERGE) begin
        wr_en[n]   = ~RST;
        wr_addr[n] = lat_a_q[n];
        wr_data[n] = (base_q[n] & ~lat_wem_q[n]) | (lat_d_q[n] & lat_wem_q[n]);
      end else if (full_wr[n]) begin
        wr_en[n] = ~RST;
      end
    end
  end

  // Next-state for both port FSMs and the response registers.
  always_comb begin
    coll_d = wr_en[0] & wr_en[1] & (wr_addr[0] == wr_addr[1]);
    for (int n = 0; n < 2; n++) begin
      state_d[n]   = state_q[n];
      lat_a_d[n]   = lat_a_q[n];
      lat_d_d[n]   = lat_d_q[n];
      lat_wem_d[n] = lat_wem_q[n];
      base_d[n]    = base_q[n];
      q_d[n]       = q_q[n];
      qv_d[n]      = rd_acc[n];
      if (rd_acc[n]) begin
        q_d[n] = mem[req_a[n]];  // read-first: sees the word before this edge
      end
      if (part_wr[n]) begin
        state_d[n]   = ST_MERGE;
        lat_a_d[n]   = req_a[n];
        lat_d_d[n]   = req_d[n];
        lat_wem_d[n] = req_wem[n];
        // The other port's write at this same edge supersedes the stale word.
        if (wr_en[1-n] && (wr_addr[1-n] == req_a[n])) begin
          base_d[n] = wr_data[1-n];
        end else begin
          base_d[n] = mem[req_a[n]];
        end
      end else if (state_q[n] == ST_MERGE) begin
        state_d[n] = ST_IDLE;  // merge written (or dropped) this edge
      end
      rdy_d[n] = (state_d[n] == ST_IDLE);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rdy_q  <= '1;
      qv_q   <= '0;
      coll_q <= 1'b0;
      for (int n = 0; n < 2; n++) begin
        state_q[n]   <= ST_IDLE;
        q_q[n]       <= '0;
        lat_a_q[n]   <= '0;
        lat_d_q[n]   <= '0;
        lat_wem_q[n] <= '0;
        base_q[n]    <= '0;
      end
    end else begin
      rdy_q  <= rdy_d;
      qv_q   <= qv_d;
      coll_q <= coll_d;
      for (int n = 0; n < 2; n++) begin
        state_q[n]   <= state_d[n];
        q_q[n]       <= q_d[n];
        lat_a_q[n]   <= lat_a_d[n];
        lat_d_q[n]   <= lat_d_d[n];
        lat_wem_q[n] <= lat_wem_d[n];
        base_q[n]    <= base_d[n];
      end
    end
  end

  // NOTE: the storage array has no reset; its contents survive RST and a
  // reset branch here would prevent mapping onto the SRAM macro.
  // Port 1 is suppressed on a same-address collision so port 0's word lands.
  always_ff @(posedge CLK) begin
    if (wr_en[0]) begin
      mem[wr_addr[0]] <= wr_data[0];
    end
    if (wr_en[1] && !coll_d) begin
      mem[wr_addr[1]] <= wr_data[1];
    end
  end

`ifdef GSRAM_OUT_REG_EN
  logic [DBITS-1:0] oq_q [2];
  logic [1:0]       oqv_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      oqv_q   <= '0;
      oq_q[0] <= '0;
      oq_q[1] <= '0;
    end else begin
      oqv_q   <= qv_q;
      oq_q[0] <= q_q[0];
      oq_q[1] <= q_q[1];
    end
  end

  assign p0.Q  = oq_q[0];
  assign p1.Q  = oq_q[1];
  assign p0.QV = oqv_q[0];
  assign p1.QV = oqv_q[1];
`else
  assign p0.Q  = q_q[0];
  assign p1.Q  = q_q[1];
  assign p0.QV = qv_q[0];
  assign p1.QV = qv_q[1];
`endif

  assign p0.RDY = rdy_q[0];
  assign p1.RDY = rdy_q[1];
  assign COLL   = coll_q;
endmodule

// File: tb/tb_gsram_dp_rmw.sv
// ---------------------------------------------------------------------------
// tb_gsram_dp_rmw
// Directed and random stimulus for gsram_dp_rmw. A transaction-level model
// (word array plus one pending-merge record per port) predicts every read
// response, RDY and COLL. Expected reads go into per-port queues; a monitor
// on the falling edge pops and compares whenever QV is seen.
// ---------------------------------------------------------------------------
module tb_gsram_dp_rmw;
  localparam int ABITS = 10;
  localparam int DBITS = 16;
`ifdef GSRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic             ce;
    logic             we;
    logic [ABITS-1:0] a;
    logic [DBITS-1:0] d;
    logic [DBITS-1:0] wem;
  } req_t;

  typedef struct {
    int               due;
    logic [DBITS-1:0] q;
  } rd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic coll;

  gsram_dp_rmw_if #(.ABITS(ABITS), .DBITS(DBITS)) if0 ();
  gsram_dp_rmw_if #(.ABITS(ABITS), .DBITS(DBITS)) if1 ();

  gsram_dp_rmw #(.ABITS(ABITS), .DBITS(DBITS)) dut (
    .CLK  (clk),
    .RST  (rst),
    .p0   (if0),
    .p1   (if1),
    .COLL (coll)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [DBITS-1:0] mem_m [1 << ABITS];
  bit               pend_act  [2];
  logic [ABITS-1:0] pend_a    [2];
  logic [DBITS-1:0] pend_d    [2];
  logic [DBITS-1:0] pend_wem  [2];
  logic [DBITS-1:0] pend_base [2];
  rd_t              rq0 [$];
  rd_t              rq1 [$];
  bit               exp_coll [0:8191];
  bit               ovr_v [2];
  logic [DBITS-1:0] ovr_q [2];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  task automatic mon_port(input int p, input logic qv, input logic [DBITS-1:0] q);
    rd_t e;
    bit  have;
    have = (p == 0) ? (rq0.size() > 0) : (rq1.size() > 0);
    if (have) begin
      if (p == 0) e = rq0[0];
      else        e = rq1[0];
    end
    if (qv) begin
      if (!have) begin
        check($sformatf("qv%0d_spurious", p), 32'd1, 32'd0);
      end else begin
        if (p == 0) e = rq0.pop_front();
        else        e = rq1.pop_front();
        check($sformatf("q%0d_data", p), q, e.q);
        check($sformatf("qv%0d_latency", p), cyc, e.due);
      end
    end else if (have && e.due <= cyc) begin
      check($sformatf("qv%0d_missing", p), 32'd0, 32'd1);
      if (p == 0) e = rq0.pop_front();
      else        e = rq1.pop_front();
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon_port(0, if0.QV, if0.Q);
      mon_port(1, if1.QV, if1.Q);
      check("coll", coll, exp_coll[cyc]);
    end
  end

  // ---------------- request builders ----------------
  function automatic req_t idle();
    req_t r;
    r = '0;
    return r;
  endfunction

  function automatic req_t rd(input int a);
    req_t r;
    r = '0;
    r.ce = 1'b1;
    r.a  = ABITS'(a);
    return r;
  endfunction

  function automatic req_t pw(input int a, input logic [DBITS-1:0] d, input logic [DBITS-1:0] wem);
    req_t r;
    r = '0;
    r.ce  = 1'b1;
    r.we  = 1'b1;
    r.a   = ABITS'(a);
    r.d   = d;
    r.wem = wem;
    return r;
  endfunction

  function automatic req_t wr(input int a, input logic [DBITS-1:0] d);
    return pw(a, d, '1);
  endfunction

  function automatic req_t rand_req();
    req_t r;
    int   k;
    r.ce = ($urandom_range(0, 3) != 0);
    r.we = 1'($urandom_range(0, 1));
    r.a  = ABITS'($urandom_range(0, 15));
    r.d  = DBITS'($urandom);
    k = $urandom_range(0, 3);
    if (k == 0)      r.wem = '1;
    else if (k == 1) r.wem = '0;
    else             r.wem = DBITS'($urandom);
    return r;
  endfunction

  task automatic set_exp(input int p, input logic [DBITS-1:0] v);
    ovr_v[p] = 1'b1;
    ovr_q[p] = v;
  endtask

  // ---------------- one clock of stimulus + model ----------------
  // Called just after a falling edge; returns just after the next one.
  task automatic step(input req_t r0, input req_t r1);
    req_t             r [2];
    bit               acc [2];
    bit               wen [2];
    logic [ABITS-1:0] wa [2];
    logic [DBITS-1:0] wd [2];
    bit               coll_m;
    int               o;
    rd_t              e;
    r[0] = r0;
    r[1] = r1;
    check("rdy0", if0.RDY, !pend_act[0]);
    check("rdy1", if1.RDY, !pend_act[1]);
    // Writes landing at this edge: a finishing merge, or a full write.
    for (int n = 0; n < 2; n++) begin
      acc[n] = r[n].ce && !pend_act[n];
      wen[n] = 1'b0;
      wa[n]  = r[n].a;
      wd[n]  = r[n].d;
      if (pend_act[n]) begin
        wen[n] = 1'b1;
        wa[n]  = pend_a[n];
        wd[n]  = (pend_base[n] & ~pend_wem[n]) | (pend_d[n] & pend_wem[n]);
      end else if (acc[n] && r[n].we && r[n].wem == '1) begin
        wen[n] = 1'b1;
      end
    end
    // Reads and merge bases see the array before this edge's writes.
    for (int n = 0; n < 2; n++) begin
      o = 1 - n;
      if (acc[n] && !r[n].we) begin
        e.due = cyc + LAT;
        e.q   = ovr_v[n] ? ovr_q[n] : mem_m[r[n].a];
        ovr_v[n] = 1'b0;
        if (n == 0) rq0.push_back(e);
        else        rq1.push_back(e);
      end
      if (acc[n] && r[n].we && r[n].wem != '0 && r[n].wem != '1) begin
        pend_act[n]  = 1'b1;
        pend_a[n]    = r[n].a;
        pend_d[n]    = r[n].d;
        pend_wem[n]  = r[n].wem;
        pend_base[n] = (wen[o] && wa[o] == r[n].a) ? wd[o] : mem_m[r[n].a];
      end else begin
        pend_act[n] = 1'b0;
      end
    end
    coll_m = wen[0] && wen[1] && (wa[0] == wa[1]);
    if (wen[1] && !coll_m) mem_m[wa[1]] = wd[1];
    if (wen[0])            mem_m[wa[0]] = wd[0];
    exp_coll[cyc + 1] = coll_m;

    if0.CE = r0.ce; if0.WE = r0.we; if0.A = r0.a; if0.D = r0.d; if0.WEM = r0.wem;
    if1.CE = r1.ce; if1.WE = r1.we; if1.A = r1.a; if1.D = r1.d; if1.WEM = r1.wem;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asserts RST between edges, holds it, checks reset outputs, releases.
  task automatic do_reset(input int cycles);
    #1;
    rst = 1'b1;
    if0.CE = 1'b0;
    if1.CE = 1'b0;
    rq0.delete();
    rq1.delete();
    pend_act[0] = 1'b0;
    pend_act[1] = 1'b0;
    for (int i = cyc; i <= cyc + cycles + 3; i++) exp_coll[i] = 1'b0;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    check("rst_q0",   if0.Q,   '0);
    check("rst_q1",   if1.Q,   '0);
    check("rst_qv0",  if0.QV,  '0);
    check("rst_qv1",  if1.QV,  '0);
    check("rst_rdy0", if0.RDY, 32'd1);
    check("rst_rdy1", if1.RDY, 32'd1);
    check("rst_coll", coll,    '0);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    if0.CE = 1'b0; if0.WE = 1'b0; if0.A = '0; if0.D = '0; if0.WEM = '0;
    if1.CE = 1'b0; if1.WE = 1'b0; if1.A = '0; if1.D = '0; if1.WEM = '0;
    ovr_v[0] = 1'b0;
    ovr_v[1] = 1'b0;
    pend_act[0] = 1'b0;
    pend_act[1] = 1'b0;
    do_reset(3);

    // Give every address used below a known value.
    for (int i = 0; i < 8; i++) step(wr(2 * i, DBITS'($urandom)), wr(2 * i + 1, DBITS'($urandom)));

    // Readback across ports at the top address.
    step(wr(10'h3FF, 16'hA5A5), idle());
    set_exp(1, 16'hA5A5);
    step(idle(), rd(10'h3FF));

    // Partial write: one MERGE cycle with RDY0 low.
    step(wr(5, 16'h1234), idle());
    step(pw(5, 16'hFFFF, 16'h00F0), idle());
    step(idle(), idle());
    set_exp(0, 16'h12F4);
    step(rd(5), idle());

    // Merge base forwarded from port 1's write at the RMW read edge.
    step(wr(7, 16'h0000), idle());
    step(pw(7, 16'h000F, 16'h000F), wr(7, 16'hAB00));
    step(idle(), idle());
    set_exp(1, 16'hAB0F);
    step(idle(), rd(7));

    // Full/full collision: port 0 wins, COLL for one cycle.
    step(wr(9, 16'h1111), wr(9, 16'h2222));
    set_exp(0, 16'h1111);
    step(rd(9), idle());
    // Port 0 merge vs port 1 full write.
    step(pw(9, 16'h00FF, 16'h00FF), idle());
    step(idle(), wr(9, 16'h3333));
    set_exp(1, 16'h11FF);
    step(idle(), rd(9));
    // Port 1 merge dropped by port 0 full write; port 1 still returns ready.
    step(idle(), pw(9, 16'hFFFF, 16'h0F0F));
    step(wr(9, 16'h4444), idle());
    set_exp(1, 16'h4444);
    step(idle(), rd(9));
    // Read-first on a same-edge write.
    set_exp(1, 16'h4444);
    step(wr(9, 16'h5555), rd(9));
    set_exp(0, 16'h5555);
    step(rd(9), idle());

    // Null write leaves the word alone and produces no strobe.
    step(pw(9, 16'hFFFF, 16'h0000), idle());
    set_exp(0, 16'h5555);
    step(rd(9), idle());

    // Reset while port 0 is in MERGE.
    step(wr(3, 16'hBEEF), idle());
    step(pw(3, 16'h0000, 16'hFF00), idle());
    do_reset(2);
    set_exp(0, 16'hBEEF);
    step(rd(3), idle());

    // Random traffic on a small address window to provoke conflicts.
    for (int i = 0; i < 400; i++) begin
      step(rand_req(), rand_req());
      if (i == 150 || i == 300) do_reset(2);
    end

    repeat (4) step(idle(), idle());
    check("drain_q0", rq0.size(), 32'd0);
    check("drain_q1", rq1.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/gsram_dp_rmw.md
# gsram_dp_rmw

Parametrised dual-port generic SRAM wrapper and successor to the fixed 1024x16 wrappers. It honours per-bit write masks through an internal read-modify-write (RMW) sequence, because the underlying `generic_sram` has no mask pins. It also returns read-data-valid strobes and applies deterministic port-collision rules. It sits between accelerator PLM logic and the `generic_sram` array in comp-kernel-only synthesis.

## Interface
Parameters:
- `ABITS`, 10, address width; depth = 2^ABITS words.
- `DBITS`, 16, data and mask width.

Ports (n = 0, 1; one set per port):
- `CLK`  in  1  clock; all state changes on its rising edge.
- `RST`  in  1  reset; asynchronous, active-high.
- `An`  in  ABITS  word address.
- `Dn`  in  DBITS  write data.
- `WEn`  in  1  1 = write, 0 = read; meaningful only with `CEn`=1.
- `WEMn`  in  DBITS  bit write mask; 1 = bit is written.
- `CEn`  in  1  request.
- `RDYn`  out  1  port can accept a request this cycle.
- `Qn`  out  DBITS  read data.
- `QVn`  out  1  one-cycle strobe: `Qn` holds fresh read data.
- `COLL`  out  1  one-cycle strobe: a port-1 write was dropped by a collision.

## Operation
- A request is accepted on a rising edge where `CEn`=1 and `RDYn`=1. Requests while `RDYn`=0 are ignored; there is no queuing.
- Each port runs a 2-state FSM, IDLE and MERGE.
- **Read** (`WEn`=0): issues an array read. `Qn` is updated and `QVn`=1 for exactly one cycle. `Qn` holds its value otherwise. The FSM stays in IDLE.
- **Full write** (`WEMn` all ones): the word is written at the accepting edge. The FSM stays in IDLE and `RDYn` stays 1.
- **Null write** (`WEn`=1, `WEMn`=0): accepted, but the array is not accessed and there is no strobe.
- **Partial write** (any other mask):
  - At the accepting edge the port latches A/D/WEM, issues an array read and enters MERGE, where `RDYn`=0.
  - In MERGE the port writes (old & ~WEM) | (D & WEM) and returns to IDLE.
  - `QVn` is not asserted for a partial write.
- **Merge-base forwarding:** if the other port wrote the same address at the RMW read edge, the merge base is that written word, not the stale array output.
- **Write/write collision:** both ports write the same address at the same edge (full or merge writes, any mix). Port 0's word lands, port 1's write is dropped, and `COLL`=1 next cycle. A dropped port-1 merge still returns to IDLE.
- **Read/write, same address, same edge:** the read returns the old word (read-first).
- **Reset:**
  - Outputs: `Qn`=0, `QVn`=0, `RDYn`=1, `COLL`=0.
  - FSMs go to IDLE.
  - Array contents are not reset.
- **Reset mid-RMW:** the pending merge is discarded and the array keeps the pre-request word.
- **Address range:** addresses are always in range (2^ABITS words), so there is no wrap or bounds logic.

## Timing
- Read latency: `Qn`/`QVn` valid 1 cycle after the accepting edge.
- Full-write throughput: 1 per cycle per port.
- Partial-write throughput: 1 per 2 cycles per port.
  - `RDYn` falls the cycle after acceptance and rises the cycle after the MERGE write.
  - The written word is visible to reads accepted from the MERGE-write edge + 1.
- `COLL` asserts in the cycle after the colliding edge.
- `RDYn` is a registered output. It does not depend combinationally on `CEn`.

## Configuration
- `GSRAM_OUT_REG_EN` defined:
  - `Qn`/`QVn` pass through an extra output register, so read latency is 2 cycles.
  - The extra stage resets to 0.
  - RMW internals use the raw array output, so RMW timing is unchanged.
- `GSRAM_OUT_REG_EN` undefined: read latency is 1 cycle, as specified above.

## Test plan
- **Reset and readback:** assert `RST` mid-run. All outputs read 0 (`RDY0`/`RDY1`=1). Full-write 0xA5A5 at address 0x3FF via port 0, then read it via port 1 → `Q1`=0xA5A5 with `QV1` one cycle later.
- **Partial write:** address 5 holds 0x1234. Port 0 partial write D=0xFFFF, WEM=0x00F0 → `RDY0` low for 1 cycle; a subsequent read returns 0x12F4.
- **Merge-base forwarding:** address 7 holds 0x0000. At one edge, port 0 partial-writes D=0x000F, WEM=0x000F, while port 1 full-writes 0xAB00 to address 7 → final word is 0xAB0F.
- **Write collision:** both ports full-write address 9 at the same edge, D0=0x1111, D1=0x2222 → word reads 0x1111; `COLL`=1 for exactly one cycle.
- **Reset mid-RMW:** address 3 holds 0xBEEF. Assert `RST` during MERGE of a partial write D=0x0000, WEM=0xFF00 → address 3 still reads 0xBEEF; `RDY0`=1 after reset.
- **Macro built:** with `GSRAM_OUT_REG_EN` defined, rerun the readback test → `QV1` arrives 2 cycles after acceptance; a null write produces no strobe and no array change.
